// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises one word per accepted request onto a UART line,
// paced by an external 1x baud tick. The frame is a start bit, DATA_BITS data bits
// sent LSB first, an optional parity bit and STOP_BITS stop bits.
// Build option: define UART_TX_PARITY_EN to add a parity bit after the data bits
// (even parity by default, odd when PARITY_ODD=1). Without the macro no parity
// state or parity logic is built.
// After the last stop bit a one-clock done pulse is issued. The FSM then waits for
// the request to be released, so a request that is held high cannot start a
// second frame.

module uart_transmitter #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk210_p,
    input  logic                 reset_p,
    input  logic                 baud_1_x_p,
    input  logic [DATA_BITS-1:0] transmit_data_p,
    input  logic                 transmit_req_p,
    output logic                 transmit_done_p,
    output logic                 tx_p
);

    // The bit counter covers 0..DATA_BITS-1. The stop counter covers one or two stop bits.
    localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    // Reject parameter values that the frame format cannot represent.
    if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_transmitter: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd7,
`endif
        S_STOP   = 3'd4,
        S_DONE   = 3'd5,
        S_REL    = 3'd6
    } state_t;

    state_t               state_q, state_n;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_n;
    logic                 stop_cnt_q, stop_cnt_n;
    logic                 tx_q, tx_n;
    logic                 done_q, done_n;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_n;
`endif

    // State and registered outputs. Reset forces the line idle immediately.
    always_ff @(posedge clk210_p or negedge reset_p) begin
        if (!reset_p) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_n;
            shift_q    <= shift_n;
            bit_cnt_q  <= bit_cnt_n;
            stop_cnt_q <= stop_cnt_n;
            tx_q       <= tx_n;
            done_q     <= done_n;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_n;
`endif
        end
    end

    // Next-state and next-output logic. Each baud tick presents the next frame bit.
    always_comb begin
        state_n    = state_q;
        shift_n    = shift_q;
        bit_cnt_n  = bit_cnt_q;
        stop_cnt_n = stop_cnt_q;
        tx_n       = tx_q;
        done_n     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_n   = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_n = 1'b1;
                if (transmit_req_p) begin
                    shift_n    = transmit_data_p;
                    bit_cnt_n  = '0;
                    stop_cnt_n = 1'b0;
`ifdef UART_TX_PARITY_EN
                    // Parity is taken from the full word before shifting begins.
                    parity_n   = (PARITY_ODD != 0) ? ~^transmit_data_p : ^transmit_data_p;
`endif
                    state_n    = S_ARMED;
                end
            end
            S_ARMED: begin
                if (baud_1_x_p) begin
                    tx_n    = 1'b0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (baud_1_x_p) begin
                    tx_n      = shift_q[0];
                    shift_n   = shift_q >> 1;
                    bit_cnt_n = '0;
                    state_n   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_1_x_p) begin
                    if (bit_cnt_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                        tx_n       = parity_q;
                        state_n    = S_PARITY;
`else
                        tx_n       = 1'b1;
                        stop_cnt_n = 1'b0;
                        state_n    = S_STOP;
`endif
                    end else begin
                        tx_n      = shift_q[0];
                        shift_n   = shift_q >> 1;
                        bit_cnt_n = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_1_x_p) begin
                    tx_n       = 1'b1;
                    stop_cnt_n = 1'b0;
                    state_n    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                tx_n = 1'b1;
                if (baud_1_x_p) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        stop_cnt_n = stop_cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                tx_n    = 1'b1;
                state_n = S_REL;
            end
            S_REL: begin
                tx_n = 1'b1;
                if (!transmit_req_p) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = S_IDLE;
            end
        endcase
    end

    assign tx_p            = tx_q;
    assign transmit_done_p = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a baud tick every 16 clocks, directed and random frames
// checked bit by bit against a frame list built from the UART framing rules.
module tb_uart_transmitter;

    localparam int unsigned DW = 8;
    localparam int unsigned SB = 1;
    localparam int unsigned PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic          baud;
    logic [DW-1:0] data;
    logic          req;
    logic          done;
    logic          tx;

    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned tick_cnt = 0;
    logic        last_tick = 1'b0;

    logic        exp_bits [0:15];
    int          exp_n;

    uart_transmitter #(
        .DATA_BITS  (DW),
        .STOP_BITS  (SB),
        .PARITY_ODD (PODD)
    ) dut (
        .clk210_p        (clk),
        .reset_p         (rst_n),
        .baud_1_x_p      (baud),
        .transmit_data_p (data),
        .transmit_req_p  (req),
        .transmit_done_p (done),
        .tx_p            (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-clock baud tick every 16 clocks.
    initial begin
        baud = 1'b0;
        forever begin
            repeat (15) @(posedge clk);
            #1 baud = 1'b1;
            @(posedge clk);
            #1 baud = 1'b0;
        end
    end

    // Count the clock edges at which the DUT saw a tick.
    always @(posedge clk) begin
        if (baud) tick_cnt <= tick_cnt + 1;
        last_tick <= baud;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bits.
    task automatic build(input logic [7:0] d);
        int ones;
        ones = 0;
        exp_n = 0;
        exp_bits[exp_n] = 1'b0;
        exp_n = exp_n + 1;
        for (int i = 0; i < int'(DW); i++) begin
            exp_bits[exp_n] = d[i];
            exp_n = exp_n + 1;
            if (d[i]) ones = ones + 1;
        end
        if (PB == 1) begin
            // Even parity makes the total count of ones even; odd makes it odd.
            exp_bits[exp_n] = (PODD == 0) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            exp_n = exp_n + 1;
        end
        for (int i = 0; i < int'(SB); i++) begin
            exp_bits[exp_n] = 1'b1;
            exp_n = exp_n + 1;
        end
    endtask

    // Send one frame and check every bit, the start latency and the done pulse.
    task automatic run_frame(input logic [7:0] d, input bit drop, input bit change_mid,
                             input logic [7:0] alt, input bit drop_mid);
        bit          found;
        int unsigned acc_ticks;
        build(d);
        data = d;
        req  = 1'b1;
        step();
        acc_ticks = tick_cnt;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("start_seen", 32'(found), 32'd1);
        if (!found) return;
        check("start_first_tick", tick_cnt - acc_ticks, 32'd1);
        check("start_on_tick_edge", 32'(last_tick), 32'd1);
        for (int k = 0; k < exp_n; k++) begin
            if (change_mid && k == 3) data = alt;
            if (drop_mid && k == 2) req = 1'b0;
            check("bit_begin", 32'(tx), 32'(exp_bits[k]));
            check("no_early_done", 32'(done), 32'd0);
            repeat (15) step();
            check("bit_end", 32'(tx), 32'(exp_bits[k]));
            step();
        end
        check("done_pulse", 32'(done), 32'd1);
        check("tx_idle_at_done", 32'(tx), 32'd1);
        if (drop) req = 1'b0;
        step();
        check("done_one_clock", 32'(done), 32'd0);
        step();
    endtask

    initial begin
        bit          saw;
        logic [7:0]  r;
        rst_n = 1'b0;
        req   = 1'b0;
        data  = '0;
        repeat (3) step();
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_tx", 32'(tx), 32'd1);

        // Single frame of 0x01.
        run_frame(8'h01, 1'b1, 1'b0, 8'h00, 1'b0);

        // Back-to-back directed frames.
        run_frame(8'h01, 1'b1, 1'b0, 8'h00, 1'b0);
        run_frame(8'h02, 1'b1, 1'b0, 8'h00, 1'b0);
        run_frame(8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        run_frame(8'h04, 1'b1, 1'b0, 8'h00, 1'b0);

        // Random frames.
        for (int i = 0; i < 6; i++) begin
            r = 8'($urandom);
            run_frame(r, 1'b1, 1'b0, 8'h00, 1'b0);
        end

        // Request held high after done: no second frame.
        run_frame(8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 60; i++) begin
            check("held_req_tx", 32'(tx), 32'd1);
            check("held_req_done", 32'(done), 32'd0);
            step();
        end
        req = 1'b0;
        step();
        step();
        r = 8'($urandom);
        run_frame(r, 1'b1, 1'b0, 8'h00, 1'b0);

        // Data change mid-frame is ignored.
        run_frame(8'hA5, 1'b1, 1'b1, 8'h5A, 1'b0);

        // Request dropped mid-frame: frame completes and done still pulses.
        r = 8'($urandom);
        run_frame(r, 1'b1, 1'b0, 8'h00, 1'b1);

        // Reset during data bit 3 (forced to 0 so the line is low there).
        r = 8'($urandom) & 8'hF7;
        data = r;
        req  = 1'b1;
        saw  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tx === 1'b0) begin
                saw = 1'b1;
                break;
            end
        end
        check("rst_frame_start", 32'(saw), 32'd1);
        repeat (16 * 4 + 5) step();
        check("bit3_low_before_reset", 32'(tx), 32'd0);
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        check("reset_mid_tx", 32'(tx), 32'd1);
        check("reset_mid_done", 32'(done), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (done === 1'b1 || tx !== 1'b1) saw = 1'b1;
        end
        check("no_activity_after_reset", 32'(saw), 32'd0);
        run_frame(8'h04, 1'b1, 1'b0, 8'h00, 1'b0);

`ifdef UART_TX_PARITY_EN
        run_frame(8'h02, 1'b1, 1'b0, 8'h00, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
